// File: rtl/instr_mem_loader.sv
// ============================================================================
// Module   : instr_mem_loader
// Purpose  : Packs a valid/ready byte stream MSB-first into B-bit words and
//            writes them to consecutive instruction-memory addresses from 0.
// Options  : LOADER_OPCODE_CHECK_EN enables the sticky bad-opcode flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_loader #(
    parameter int B = 32,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N:0]   load_len,
    input  logic         in_valid,
    input  logic [7:0]   in_byte,
    output logic         in_ready,
    output logic         wr_en,
    output logic [N-1:0] wr_addr,
    output logic [B-1:0] wr_data,
    output logic         busy,
    output logic         done,
    output logic [N:0]   word_count,
    output logic         err_opcode
);

    localparam int BPW = B / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [N:0]    CAPACITY  = {1'b1, {N{1'b0}}};
    localparam logic [CW-1:0] LAST_BYTE = CW'(BPW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic [N:0]    r_len;
    logic [N-1:0]  r_addr;
    logic [CW-1:0] r_bcnt;

    logic [N:0]    w_len;
    logic [N:0]    w_count_next;
    logic          w_accept;
    logic [B-1:0]  w_shift_next;

    assign w_len        = (load_len > CAPACITY) ? CAPACITY : load_len;
    assign w_count_next = word_count + 1'b1;
    assign w_accept     = in_ready & in_valid;

    // Only the low B-8 bits of the shift register survive into the next word.
    generate
        if (B == 8) begin : g_single_byte
            assign w_shift_next = in_byte;
        end else begin : g_multi_byte
            logic [B-9:0] r_shift;
            assign w_shift_next = {r_shift, in_byte};
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_shift <= '0;
                end else if (w_accept) begin
                    r_shift <= w_shift_next[B-9:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_addr     <= '0;
            r_bcnt     <= '0;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
`ifdef LOADER_OPCODE_CHECK_EN
            err_opcode <= 1'b0;
`endif
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len      <= w_len;
                        r_addr     <= '0;
                        r_bcnt     <= '0;
                        wr_addr    <= '0;
                        word_count <= '0;
`ifdef LOADER_OPCODE_CHECK_EN
                        err_opcode <= 1'b0;
`endif
                        if (w_len == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state  <= S_LOAD;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (r_bcnt == LAST_BYTE) begin
                            r_bcnt   <= '0;
                            r_state  <= S_WRITE;
                            in_ready <= 1'b0;
                            wr_en    <= 1'b1;
                            wr_data  <= w_shift_next;
                            wr_addr  <= r_addr;
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_addr     <= r_addr + 1'b1;
                    word_count <= w_count_next;
`ifdef LOADER_OPCODE_CHECK_EN
                    if (wr_data[B-1:B-6] > 6'd2) begin
                        err_opcode <= 1'b1;
                    end
`endif
                    if (w_count_next == r_len) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_state  <= S_LOAD;
                        in_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

`ifndef LOADER_OPCODE_CHECK_EN
    assign err_opcode = 1'b0;
`endif

endmodule

`default_nettype wire
